// File: rtl/mmio_write_queue_pkg.sv
// Shared types and constants for the display-window store queue.
// Window constants, the queued write record and the window-decode helper.
package mmio_pkg;

    localparam logic [31:0] TUBE_BASE  = 32'h7f50;
    localparam int          TUBE_SPAN  = 8;
    localparam int          DROP_CNT_W = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
    } mmio_wr_t;

    // True when a lies inside [base, base+span-1]; 33-bit math avoids wrap at the top of memory.
    function automatic logic in_window(input logic [31:0] a, input logic [31:0] base, input int span);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = {1'b0, base} + 33'(span) - 33'd1;
        return ({1'b0, a} >= lo) && ({1'b0, a} <= hi);
    endfunction

endpackage

// File: rtl/mmio_write_queue_if.sv
// Store-request and peripheral write-bus bundle for mmio_write_queue.
// master: CPU/bridge side plus downstream ready; slave: the queue itself.
interface mmio_write_queue_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        dev_ready;
    logic [3:0]  byteen;
    logic [31:0] Addr;
    logic [31:0] WD;

    modport master (
        output req_valid, req_addr, req_byteen, req_wdata, dev_ready,
        input  req_ready, byteen, Addr, WD
    );

    modport slave (
        input  req_valid, req_addr, req_byteen, req_wdata, dev_ready,
        output req_ready, byteen, Addr, WD
    );

endinterface

// File: rtl/mmio_write_queue_mem.sv
// Entry storage for mmio_write_queue: DEPTH records, one write port, one async read port.
// A merge write ORs in the new lane enables and overwrites only the enabled data lanes,
// leaving the stored address untouched. Storage is deliberately not reset.
module mmio_wq_mem
    import mmio_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_merge,
    input  logic [AW-1:0] wr_idx,
    input  mmio_wr_t      wr_ent,
    input  logic [AW-1:0] rd_idx,
    output mmio_wr_t      rd_ent
);

    logic [31:0] addr_q   [DEPTH];
    logic [3:0]  byteen_q [DEPTH];
    logic [31:0] rd_wdata;

    // Address is written only when a fresh entry is allocated.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_merge) begin
            addr_q[wr_idx] <= wr_ent.addr;
        end
    end

    // Lane enables accumulate on merge, replace on allocation.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            byteen_q[wr_idx] <= wr_merge ? (byteen_q[wr_idx] | wr_ent.byteen) : wr_ent.byteen;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q [DEPTH];

        // Per-lane data write: all lanes on allocation, only enabled lanes on merge.
        always_ff @(posedge clk) begin
            if (wr_en && (!wr_merge || wr_ent.byteen[gi])) begin
                lane_q[wr_idx] <= wr_ent.wdata[8*gi +: 8];
            end
        end

        assign rd_wdata[8*gi +: 8] = lane_q[rd_idx];
    end

    assign rd_ent = '{addr: addr_q[rd_idx], byteen: byteen_q[rd_idx], wdata: rd_wdata};

endmodule

// File: rtl/mmio_write_queue.sv
// Store queue between the bridge store path and the digital-tube register block.
// Filters out-of-window / empty-lane stores (counting them), buffers the rest FIFO-style
// and presents the head on byteen/Addr/WD, zeros when empty.
// Optional feature: define MMIO_WRITE_MERGE_EN to merge same-word stores into the tail.
module mmio_write_queue
    import mmio_pkg::*;
#(
    parameter  int          DEPTH     = 4,
    parameter  logic [31:0] BASE_ADDR = TUBE_BASE,
    parameter  int          SPAN      = TUBE_SPAN,
    localparam int          AW        = $clog2(DEPTH),
    localparam int          LW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_write_queue_if.slave     bus,
    output logic [LW-1:0]         level,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic     full, accept, push_ok, drop, pop, merge, push;
    logic     wr_en;
    logic [AW-1:0] wr_idx;
    mmio_wr_t req_ent, head_ent;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign bus.req_ready = !full;
    assign accept    = bus.req_valid && !full;
    assign push_ok   = accept && in_window(bus.req_addr, BASE_ADDR, SPAN) && (bus.req_byteen != 4'b0);
    assign drop      = accept && !push_ok;
    assign pop       = (level_q != '0) && bus.dev_ready;

`ifdef MMIO_WRITE_MERGE_EN
    logic [29:0] tail_word_q;

    // The tail is only mergeable if it is not leaving the queue at this same edge.
    assign merge = push_ok && (level_q != '0) && (bus.req_addr[31:2] == tail_word_q)
                   && !((level_q == LW'(1)) && bus.dev_ready);

    // Remember the word address of the most recently allocated entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tail_word_q <= '0;
        end else if (push) begin
            tail_word_q <= bus.req_addr[31:2];
        end
    end
`else
    assign merge = 1'b0;
`endif

    assign push    = push_ok && !merge;
    assign wr_en   = push || merge;
    assign wr_idx  = merge ? (wr_ptr_q[AW-1:0] - AW'(1)) : wr_ptr_q[AW-1:0];
    assign req_ent = '{addr: bus.req_addr, byteen: bus.req_byteen, wdata: bus.req_wdata};

    mmio_wq_mem #(.DEPTH(DEPTH)) u_mem (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_merge (merge),
        .wr_idx   (wr_idx),
        .wr_ent   (req_ent),
        .rd_idx   (rd_ptr_q[AW-1:0]),
        .rd_ent   (head_ent)
    );

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        level_d    = level_q + LW'(push) - LW'(pop);
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Queue state registers; the async reset empties the queue and clears the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Head is visible only while something is queued.
    assign bus.byteen = (level_q != '0) ? head_ent.byteen : 4'b0;
    assign bus.Addr   = (level_q != '0) ? head_ent.addr   : 32'h0;
    assign bus.WD     = (level_q != '0) ? head_ent.wdata  : 32'h0;
    assign level      = level_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
